// File: rtl/bpu_assoc_gshare_pkg.sv
// Shared types and default geometry for the associative gshare branch predictor.
package bpu_assoc_gshare_pkg;

  // Kind of control-flow instruction stored in a BTB entry.
  // A call is stored as JUMP and distinguished by the link flag on update.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    RETURN = 2'd3
  } btb_type_t;

  // Default geometry; the top-level parameters take these as defaults.
  localparam int BPU_NUM_BTB_WAYS = 2;
  localparam int BPU_GHR_WIDTH    = 8;

  // Width of a way index; at least one bit so the port never collapses.
  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  localparam int BPU_WAY_W = way_width(BPU_NUM_BTB_WAYS);

  // Prediction metadata carried down the pipe and returned on update.
  typedef struct packed {
    logic                     btb_hit;
    logic [BPU_WAY_W-1:0]     way;
    logic [BPU_GHR_WIDTH-1:0] ghr;
  } bpu_meta_t;

endpackage

// File: rtl/bpu_assoc_gshare_sat_counter_table.sv
// Table of saturating counters: one combinational read port and one
// read-modify-write training port. Counters reset to weakly not-taken.
module sat_counter_table #(
  parameter int NUM_ENTRIES = 1024,
  parameter int CTR_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(NUM_ENTRIES)-1:0] rd_idx,
  output logic [CTR_WIDTH-1:0]           rd_ctr,
  input  logic                           upd_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0] upd_idx,
  input  logic                           upd_inc
);

  localparam logic [CTR_WIDTH-1:0] CTR_RST = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  logic [CTR_WIDTH-1:0] ctr [NUM_ENTRIES];
  logic [CTR_WIDTH-1:0] upd_cur;

  assign rd_ctr  = ctr[rd_idx];
  assign upd_cur = ctr[upd_idx];

  // Train the addressed counter, saturating at both ends.
  // NOTE: state is assigned with <= so every flop samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ctr[i] <= CTR_RST;
    end else if (upd_en) begin
      if (upd_inc && upd_cur != CTR_MAX)       ctr[upd_idx] <= upd_cur + 1'b1;
      else if (!upd_inc && upd_cur != '0)      ctr[upd_idx] <= upd_cur - 1'b1;
    end
  end

endmodule

// File: rtl/bpu_assoc_gshare.sv
// Branch prediction unit: set-associative BTB with round-robin replacement,
// gshare direction table and circular return address stack. A query at T
// yields a registered prediction at T+1; the update port trains all tables.
module bpu_assoc_gshare
  import bpu_assoc_gshare_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 512,
  parameter int NUM_BTB_WAYS    = BPU_NUM_BTB_WAYS,
  parameter int NUM_PHT_ENTRIES = 1024,
  parameter int CTR_WIDTH       = 2,
  parameter int GHR_WIDTH       = BPU_GHR_WIDTH,
  parameter int NUM_RAS         = 16,
  localparam int WAY_W          = way_width(NUM_BTB_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 query_valid,
  input  logic [31:0]          query_pc,
  input  logic                 flush,
  output logic                 predict_valid,
  output logic [31:0]          predict_target,
  output logic                 predict_btb_hit,
  output logic [WAY_W-1:0]     predict_way,
  output logic [GHR_WIDTH-1:0] predict_ghr,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [31:0]          upd_link_pc,
  input  logic [31:0]          upd_target,
  input  logic                 upd_taken,
  input  logic [1:0]           upd_type,
  input  logic                 upd_is_call,
  input  logic                 upd_is_ret,
  input  logic                 upd_miss,
  input  logic                 upd_btb_hit,
  input  logic [WAY_W-1:0]     upd_way,
  input  logic [GHR_WIDTH-1:0] upd_ghr
);

  localparam int NUM_SETS = NUM_BTB_ENTRIES / NUM_BTB_WAYS;
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = 32 - IDX_W - 2;
  localparam int PHT_W    = $clog2(NUM_PHT_ENTRIES);
  localparam int SP_W     = $clog2(NUM_RAS);
  localparam int CNT_W    = SP_W + 1;

  // BTB storage: valid and replacement pointers are flops, payload is RAM.
  logic [NUM_BTB_WAYS-1:0] btb_valid  [NUM_SETS];
  logic [WAY_W-1:0]        rr_ptr     [NUM_SETS];
  logic [TAG_W-1:0]        btb_tag    [NUM_SETS][NUM_BTB_WAYS];
  logic [31:0]             btb_target [NUM_SETS][NUM_BTB_WAYS];
  btb_type_t               btb_type   [NUM_SETS][NUM_BTB_WAYS];

  logic [GHR_WIDTH-1:0] ghr;
  logic [31:0]          ras [NUM_RAS];
  logic [SP_W-1:0]      ras_sp;
  logic [CNT_W-1:0]     ras_count;
  logic [31:0]          ras_top;

  bpu_meta_t meta_q;

  // Query-side decode.
  logic [IDX_W-1:0]     q_set;
  logic [TAG_W-1:0]     q_tag;
  logic                 q_hit;
  logic [WAY_W-1:0]     q_way;
  btb_type_t            q_type;
  logic [PHT_W-1:0]     q_pht_idx;
  logic [CTR_WIDTH-1:0] q_ctr;
  logic                 q_taken;
  logic                 q_pred_valid;
  logic [31:0]          q_pred_target;

  // Update-side decode.
  btb_type_t        u_type;
  logic [IDX_W-1:0] u_set;
  logic             btb_wr;
  logic [WAY_W-1:0] wr_way;
  logic [WAY_W-1:0] rr_next;
  logic             ras_push;
  logic             ras_replace;
  logic             ras_pop;
  logic [SP_W-1:0]  ras_wr_idx;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{query_pc[1:0], upd_pc[1:0]};

  assign q_set     = query_pc[IDX_W+1:2];
  assign q_tag     = query_pc[31:IDX_W+2];
  assign q_pht_idx = query_pc[PHT_W+1:2] ^ PHT_W'(ghr);
  assign q_taken   = q_ctr[CTR_WIDTH-1];
  assign ras_top   = ras[ras_sp - SP_W'(1)];

  assign u_type  = btb_type_t'(upd_type);
  assign u_set   = upd_pc[IDX_W+1:2];
  assign btb_wr  = upd_valid && upd_miss && (u_type != NONE);
  assign wr_way  = upd_btb_hit ? upd_way : rr_ptr[u_set];
  assign rr_next = (NUM_BTB_WAYS > 1) ? rr_ptr[u_set] + WAY_W'(1) : '0;

  sat_counter_table #(
    .NUM_ENTRIES (NUM_PHT_ENTRIES),
    .CTR_WIDTH   (CTR_WIDTH)
  ) u_pht (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (q_pht_idx),
    .rd_ctr  (q_ctr),
    .upd_en  (upd_valid && (u_type == BRANCH)),
    .upd_idx (upd_pc[PHT_W+1:2] ^ PHT_W'(upd_ghr)),
    .upd_inc (upd_taken)
  );

  // Tag match across the ways of the queried set; lowest matching way wins.
  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    q_hit = 1'b0;
    q_way = '0;
    for (int w = NUM_BTB_WAYS - 1; w >= 0; w--) begin
      if (btb_valid[q_set][w] && btb_tag[q_set][w] == q_tag) begin
        q_hit = 1'b1;
        q_way = WAY_W'(w);
      end
    end
  end

  // Form the redirect from the hit entry, counter and return stack.
  always_comb begin
    q_type        = btb_type[q_set][q_way];
    q_pred_valid  = 1'b0;
    q_pred_target = '0;
    if (q_hit) begin
      q_pred_target = (q_type == RETURN) ? ras_top : btb_target[q_set][q_way];
      case (q_type)
        BRANCH:  q_pred_valid = q_taken;
        JUMP:    q_pred_valid = 1'b1;
        RETURN:  q_pred_valid = (ras_count != '0);
        default: q_pred_valid = 1'b0;
      endcase
    end
  end

  // Register the prediction; no query or a flush yields all-zero outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      predict_valid  <= 1'b0;
      predict_target <= '0;
      meta_q         <= '0;
    end else if (query_valid && !flush) begin
      predict_valid  <= q_pred_valid;
      predict_target <= q_pred_target;
      meta_q         <= '{btb_hit: q_hit, way: q_way, ghr: ghr};
    end else begin
      predict_valid  <= 1'b0;
      predict_target <= '0;
      meta_q         <= '0;
    end
  end

  assign predict_btb_hit = meta_q.btb_hit;
  assign predict_way     = meta_q.way;
  assign predict_ghr     = meta_q.ghr;

  // Global history: misprediction repair outranks the speculative shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (upd_valid && upd_miss) begin
      ghr <= (u_type == BRANCH) ? {upd_ghr[GHR_WIDTH-2:0], upd_taken} : upd_ghr;
    end else if (query_valid && !flush && q_hit && q_type == BRANCH) begin
      ghr <= {ghr[GHR_WIDTH-2:0], q_taken};
    end
  end

  // BTB valid bits and round-robin pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        btb_valid[s] <= '0;
        rr_ptr[s]    <= '0;
      end
    end else if (btb_wr) begin
      btb_valid[u_set][wr_way] <= 1'b1;
      if (!upd_btb_hit) rr_ptr[u_set] <= rr_next;
    end
  end

  // BTB payload write.
  // NOTE: payload arrays have no reset so they can map to RAM; valid bits mask them.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[u_set][wr_way]    <= upd_pc[31:IDX_W+2];
      btb_target[u_set][wr_way] <= upd_target;
      btb_type[u_set][wr_way]   <= u_type;
    end
  end

  // Return stack actions: push on call, pop on return, replace top on both.
  always_comb begin
    ras_push    = 1'b0;
    ras_replace = 1'b0;
    ras_pop     = 1'b0;
    if (upd_valid) begin
      ras_push    = upd_is_call && (!upd_is_ret || ras_count == '0);
      ras_replace = upd_is_call && upd_is_ret && (ras_count != '0);
      ras_pop     = upd_is_ret && !upd_is_call && (ras_count != '0);
    end
    ras_wr_idx = ras_replace ? ras_sp - SP_W'(1) : ras_sp;
  end

  // Stack pointer and occupancy; a full push overwrites the oldest slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_sp    <= '0;
      ras_count <= '0;
    end else if (ras_push) begin
      ras_sp <= ras_sp + SP_W'(1);
      if (ras_count != CNT_W'(NUM_RAS)) ras_count <= ras_count + CNT_W'(1);
    end else if (ras_pop) begin
      ras_sp    <= ras_sp - SP_W'(1);
      ras_count <= ras_count - CNT_W'(1);
    end
  end

  // Return stack storage.
  always_ff @(posedge clk) begin
    if (ras_push || ras_replace) ras[ras_wr_idx] <= upd_link_pc;
  end

endmodule

// File: tb/tb_bpu_assoc_gshare.sv
// Directed self-checking bench for bpu_assoc_gshare with an expectation queue.
module tb_bpu_assoc_gshare;
  import bpu_assoc_gshare_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        query_valid = 1'b0;
  logic [31:0] query_pc = '0;
  logic        flush = 1'b0;
  logic        predict_valid;
  logic [31:0] predict_target;
  logic        predict_btb_hit;
  logic [0:0]  predict_way;
  logic [7:0]  predict_ghr;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_link_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic [1:0]  upd_type = '0;
  logic        upd_is_call = 1'b0;
  logic        upd_is_ret = 1'b0;
  logic        upd_miss = 1'b0;
  logic        upd_btb_hit = 1'b0;
  logic [0:0]  upd_way = '0;
  logic [7:0]  upd_ghr = '0;

  always #5 clk = ~clk;

  bpu_assoc_gshare dut (
    .clk             (clk),
    .rst             (rst),
    .query_valid     (query_valid),
    .query_pc        (query_pc),
    .flush           (flush),
    .predict_valid   (predict_valid),
    .predict_target  (predict_target),
    .predict_btb_hit (predict_btb_hit),
    .predict_way     (predict_way),
    .predict_ghr     (predict_ghr),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_link_pc     (upd_link_pc),
    .upd_target      (upd_target),
    .upd_taken       (upd_taken),
    .upd_type        (upd_type),
    .upd_is_call     (upd_is_call),
    .upd_is_ret      (upd_is_ret),
    .upd_miss        (upd_miss),
    .upd_btb_hit     (upd_btb_hit),
    .upd_way         (upd_way),
    .upd_ghr         (upd_ghr)
  );

  typedef struct {
    logic        valid;
    logic [31:0] tgt;
    logic        hit;
    logic        way;
    logic [7:0]  ghr;
    bit          chk_tgt;
    bit          chk_way;
    string       tag;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] mg = '0;   // model of the global history register
  bit         pushed = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic v, input logic [31:0] t, input logic h,
                          input logic w, input logic [7:0] g, input string tag);
    exp_t e;
    e.valid   = v;
    e.tgt     = t;
    e.hit     = h;
    e.way     = w;
    e.ghr     = g;
    e.chk_tgt = v || (!h && g == 8'h00 && !v && tag == "idle");
    e.chk_way = h || (tag == "idle");
    e.tag     = tag;
    exp_q.push_back(e);
    pushed = 1'b1;
  endtask

  // One clock: idle cycles expect all-zero outputs; compare at the falling edge.
  task automatic tick();
    exp_t e;
    if (!pushed) push_exp(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, "idle");
    pushed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    query_valid = 1'b0; flush = 1'b0; upd_valid = 1'b0; upd_miss = 1'b0;
    upd_is_call = 1'b0; upd_is_ret = 1'b0; upd_btb_hit = 1'b0;
    e = exp_q.pop_front();
    check({e.tag, ".valid"}, 32'(predict_valid), 32'(e.valid));
    check({e.tag, ".hit"}, 32'(predict_btb_hit), 32'(e.hit));
    check({e.tag, ".ghr"}, 32'(predict_ghr), 32'(e.ghr));
    if (e.chk_tgt) check({e.tag, ".target"}, predict_target, e.tgt);
    if (e.chk_way) check({e.tag, ".way"}, 32'(predict_way), 32'(e.way));
  endtask

  task automatic query(input logic [31:0] pc, input logic fl, input logic h, input logic w,
                       input logic v, input logic [31:0] t, input logic is_br, input string tag);
    query_valid = 1'b1;
    query_pc    = pc;
    flush       = fl;
    if (fl) push_exp(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, "idle");
    else    push_exp(v, t, h, w, mg, tag);
    if (!fl && h && is_br) mg = {mg[6:0], v};
    tick();
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] link, input logic [31:0] tgt,
                     input logic taken, input btb_type_t typ, input logic call, input logic ret,
                     input logic miss, input logic bhit, input logic w, input logic [7:0] g);
    upd_valid = 1'b1; upd_pc = pc; upd_link_pc = link; upd_target = tgt;
    upd_taken = taken; upd_type = typ; upd_is_call = call; upd_is_ret = ret;
    upd_miss = miss; upd_btb_hit = bhit; upd_way = w; upd_ghr = g;
    if (miss) mg = (typ == BRANCH) ? {g[6:0], taken} : g;
    tick();
  endtask

  task automatic set_ghr(input logic [7:0] g);
    upd(32'h0, 32'h0, 32'h0, 1'b0, NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, g);
  endtask

  task automatic br_train(input logic taken);
    upd(32'h200, 32'h0, 32'h300, taken, BRANCH, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and a cold query.
    tick();
    query(32'h8000_0010, 0, 0, 0, 0, 32'h0, 0, "cold");

    // Jump installed by a miss update, then hit.
    upd(32'h100, 32'h0, 32'h400, 1, JUMP, 0, 0, 1, 0, 0, 8'h00);
    query(32'h100, 0, 1, 0, 1, 32'h400, 0, "jump_hit");

    // Round-robin eviction in set 0x40.
    upd(32'h900, 32'h0, 32'hA00, 1, JUMP, 0, 0, 1, 0, 0, 8'h00);
    upd(32'h1100, 32'h0, 32'hB00, 1, JUMP, 0, 0, 1, 0, 0, 8'h00);
    query(32'h100, 0, 0, 0, 0, 32'h0, 0, "evicted");
    query(32'h900, 0, 1, 1, 1, 32'hA00, 0, "alias1");
    query(32'h1100, 0, 1, 0, 1, 32'hB00, 0, "alias2");
    // Overwrite of a known way leaves the round-robin pointer alone.
    upd(32'h900, 32'h0, 32'hC00, 1, JUMP, 0, 0, 1, 1, 1, 8'h00);
    query(32'h900, 0, 1, 1, 1, 32'hC00, 0, "overwrite");
    upd(32'h1900, 32'h0, 32'hD00, 1, JUMP, 0, 0, 1, 0, 0, 8'h00);
    query(32'h1900, 0, 1, 1, 1, 32'hD00, 0, "rr_way1");
    query(32'h900, 0, 0, 0, 0, 32'h0, 0, "rr_evict");
    query(32'h1100, 0, 1, 0, 1, 32'hB00, 0, "rr_keep");

    // Branch counter training; installed with a history that indexes elsewhere.
    upd(32'h200, 32'h0, 32'h300, 1, BRANCH, 0, 0, 1, 0, 0, 8'h80);
    check("ghr_model_after_install", 32'(mg), 32'h01);
    set_ghr(8'h00);
    query(32'h200, 0, 1, 0, 0, 32'h300, 1, "br_ctr1");
    br_train(1);
    query(32'h200, 0, 1, 0, 1, 32'h300, 1, "br_ctr2");
    set_ghr(8'h00);
    br_train(1);
    br_train(1);
    query(32'h200, 0, 1, 0, 1, 32'h300, 1, "br_ctr3sat");
    set_ghr(8'h00);
    br_train(0);
    query(32'h200, 0, 1, 0, 1, 32'h300, 1, "br_nt_ctr2");
    set_ghr(8'h00);
    br_train(0);
    query(32'h200, 0, 1, 0, 0, 32'h300, 1, "br_nt_ctr1");
    br_train(0);
    br_train(0);
    br_train(1);
    query(32'h200, 0, 1, 0, 0, 32'h300, 1, "br_sat0_ctr1");

    // Return stack: install a RETURN entry, overflow with 17 calls, drain.
    upd(32'h700, 32'h0, 32'hDEAD0, 1, RETURN, 0, 1, 1, 0, 0, 8'h00);
    query(32'h700, 0, 1, 0, 0, 32'h0, 0, "ras_empty");
    for (int k = 0; k <= 16; k++)
      upd(32'h5000, 32'h1000 + 32'(4 * k), 32'h8000, 1, JUMP, 1, 0, 0, 1, 0, 8'h00);
    query(32'h700, 0, 1, 0, 1, 32'h1040, 0, "ras_wrap_top");
    for (int k = 0; k < 15; k++)
      upd(32'h6000, 32'h0, 32'h0, 1, RETURN, 0, 1, 0, 1, 0, 8'h00);
    query(32'h700, 0, 1, 0, 1, 32'h1004, 0, "ras_last");
    upd(32'h6000, 32'h0, 32'h0, 1, RETURN, 0, 1, 0, 1, 0, 8'h00);
    query(32'h700, 0, 1, 0, 0, 32'h0, 0, "ras_drained");
    upd(32'h6000, 32'h0, 32'h0, 1, RETURN, 0, 1, 0, 1, 0, 8'h00);
    upd(32'h6000, 32'hABC, 32'h0, 1, JUMP, 1, 1, 0, 1, 0, 8'h00);
    query(32'h700, 0, 1, 0, 1, 32'hABC, 0, "callret_push");
    upd(32'h6000, 32'hDEF, 32'h0, 1, JUMP, 1, 1, 0, 1, 0, 8'h00);
    query(32'h700, 0, 1, 0, 1, 32'hDEF, 0, "callret_repl");
    upd(32'h6000, 32'h0, 32'h0, 1, RETURN, 0, 1, 0, 1, 0, 8'h00);
    query(32'h700, 0, 1, 0, 0, 32'h0, 0, "callret_pop");

    // Flush cancels the prediction and the speculative history shift.
    br_train(1);
    br_train(1);
    set_ghr(8'h00);
    query(32'h200, 1, 1, 0, 1, 32'h300, 1, "flushed");
    query(32'h200, 0, 1, 0, 1, 32'h300, 1, "after_flush");
    upd(32'h2000, 32'h0, 32'h2400, 1, BRANCH, 0, 0, 1, 0, 0, 8'h5A);
    query(32'h8000_0010, 0, 0, 0, 0, 32'h0, 0, "ghr_repair");

    // Reset in the middle of a query discards it and clears the tables.
    query_valid = 1'b1;
    query_pc    = 32'h1100;
    rst         = 1'b1;
    mg          = 8'h00;
    push_exp(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, "rst_mid");
    tick();
    rst = 1'b0;
    tick();
    query(32'h1100, 0, 0, 0, 0, 32'h0, 0, "post_rst");

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpu_assoc_gshare.md
Name: bpu_assoc_gshare

Overview:
- Second-generation branch prediction unit in the frontend, between PC generation and IFU.
- Predicts the next fetch PC one cycle after a query, using:
  - an N-way set-associative BTB with round-robin replacement,
  - a gshare PHT of parametrised saturating counters indexed by PC XOR global history,
  - a circular return address stack with overflow wrap.
- Backend update port trains all three structures and repairs speculative global history on misprediction.

Parameters:
- NUM_BTB_ENTRIES, 512, total BTB entries; power of two.
- NUM_BTB_WAYS, 2, associativity; power of two, divides NUM_BTB_ENTRIES.
- NUM_PHT_ENTRIES, 1024, gshare counters; power of two.
- CTR_WIDTH, 2, PHT counter width, 1..4.
- GHR_WIDTH, 8, global history bits; must not exceed log2(NUM_PHT_ENTRIES).
- NUM_RAS, 16, RAS depth; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- query_valid  in  1  lookup request this cycle.
- query_pc  in  32  address being fetched.
- flush  in  1  cancel in-flight query.
- predict_valid  out  1  predict_target is a taken redirect.
- predict_target  out  32  predicted next PC.
- predict_btb_hit  out  1  BTB hit meta, carried down the pipe.
- predict_way  out  log2(NUM_BTB_WAYS)  hit way meta.
- predict_ghr  out  GHR_WIDTH  GHR snapshot used for this prediction.
- upd_valid  in  1  backend resolved a control-flow instruction.
- upd_pc  in  32  instruction PC.
- upd_link_pc  in  32  PC+4 of the instruction, pushed on call.
- upd_target  in  32  actual target.
- upd_taken  in  1  actual direction.
- upd_type  in  2  btb_type_t of the instruction.
- upd_is_call, upd_is_ret  in  1 each  link semantics.
- upd_miss  in  1  instruction was mispredicted.
- upd_btb_hit, upd_way, upd_ghr  in  as predict_*  returned meta.

Behaviour:
- Address split:
  - BTB index = pc[2+IDX-1:2], IDX = log2(NUM_BTB_ENTRIES/NUM_BTB_WAYS); tag = pc[31:IDX+2].
  - PHT index = pc[2+P-1:2] XOR zero-extended GHR, P = log2(NUM_PHT_ENTRIES).
- Query latency:
  - query at cycle T produces the response at T+1 from registered meta.
  - Without a query at T, outputs at T+1 hold 0.
  - flush at T forces all outputs at T+1 to 0.
- Hit logic: hit = any way valid with matching tag; lowest-numbered matching way wins.
- Prediction at T+1:
  - BRANCH: predict_valid = hit & counter MSB.
  - JUMP, CALL: predict_valid = hit.
  - RETURN: predict_valid = hit & (ras_count != 0).
  - predict_target = RAS top for RETURN, otherwise the BTB target.
  - predict_ghr = GHR value used for the index at T.
- Speculative GHR: at T+1, if hit & BRANCH & no flush, ghr <= {ghr[GHR_WIDTH-2:0], counter MSB}.
- Update, same edge as upd_valid:
  - BTB write when upd_miss & upd_type != NONE.
    - upd_btb_hit set: overwrite way upd_way.
    - Otherwise: write way rr_ptr[set], then rr_ptr[set] <= rr_ptr+1 (mod NUM_BTB_WAYS).
    - Written entry: valid=1, tag, target, type.
  - PHT, upd_type == BRANCH only: counter at (upd_pc, upd_ghr) saturating +1 if upd_taken, else -1. No wrap at 0 or 2^CTR_WIDTH-1.
  - GHR repair when upd_miss:
    - BRANCH: ghr <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}.
    - Other types: ghr <= upd_ghr.
    - Repair has priority over the speculative shift in the same cycle.
- RAS, circular:
  - sp points to the next free slot; count saturates at NUM_RAS; top = ras[sp-1].
  - Call only: ras[sp] <= upd_link_pc, sp+1 with wrap; when full, the oldest entry is overwritten and count stays NUM_RAS.
  - Ret only: if count != 0, sp-1 and count-1; else no change.
  - Call & ret together: replace top with upd_link_pc; sp unchanged; if count == 0, push instead.
- Simultaneous update and query to the same set: the query reads pre-update contents; no bypass.
- Reset:
  - All BTB valid bits, rr_ptr, ghr, sp, count and outputs go to 0.
  - PHT counters go to 2^(CTR_WIDTH-1)-1 (weakly not taken).
  - Valid bits, counters and RAS pointers are flops; BTB tag/target/type arrays may be BRAM since they are masked by valid.
  - Reset mid-query discards the query.

Decomposition:
- Shared package bundle gains:
  - btb_type_t {NONE=0, BRANCH=1, JUMP=2, RETURN=3}; CALL is JUMP plus upd_is_call.
  - bpu_meta_t {btb_hit, way, ghr}, parametrised via package constants.
- One sub-module: sat_counter_table. Holds the CTR_WIDTH-wide counter array with one read port, one read-modify-write update port, and its reset value.

Test Plan:
- Reset, then query 0x8000_0010 → T+1: predict_valid=0, predict_btb_hit=0, predict_ghr=0.
- Update JUMP miss pc=0x100, target=0x400; query 0x100 → T+1: hit, predict_valid=1, target=0x400, way=0.
- NUM_BTB_WAYS=2: three miss updates to aliasing PCs 0x100, 0x900, 0x1100 (same set) → third write evicts 0x100; query 0x100 misses; 0x900 and 0x1100 hit.
- BRANCH at 0x200 with 0x300 in BTB, taken updates with upd_ghr=0: counter 1→2→3→3 (saturates); predict_valid becomes 1 after the 1st update; four not-taken updates saturate at 0.
- 17 calls with link pc 0x1000+4k (k=0..16), NUM_RAS=16 → count=16; RETURN entry query predicts 0x1040; 16 rets → count 0, then RETURN predict_valid=0.
- Query hit BRANCH at T and flush at T → T+1 outputs 0 and ghr unchanged; a miss update with upd_ghr=0x5A, taken → ghr=0xB5.
